// File: rtl/fc_input_packer_if.sv
// Handshake and beat bus between the word stream, the packer and the FC layer.
interface fc_input_packer_if #(
   parameter int unsigned DATA_BITS = 32,
   parameter int unsigned LANES     = 128,
   parameter int unsigned BEATS     = 4
);
   localparam int unsigned VEC    = LANES * BEATS;
   localparam int unsigned FILL_W = $clog2(VEC + 1);
   localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned VCNT_W = 16;
   localparam int unsigned BUS_W  = LANES * DATA_BITS;

   logic                 s_valid;
   logic [DATA_BITS-1:0] s_data;
   logic                 s_ready;
   logic                 flush;
   logic                 fc_busy;
   logic                 valid_out;
   logic [BUS_W-1:0]     lanes;
   logic [BEAT_W-1:0]    beat_idx;
   logic                 last_beat;
   logic [FILL_W-1:0]    fill_count;
   logic [VCNT_W-1:0]    vec_count;

   // Upstream / control side (word source and FC layer status).
   modport master (
      output s_valid, s_data, flush, fc_busy,
      input  s_ready, valid_out, lanes, beat_idx, last_beat, fill_count, vec_count
   );

   // Packer side.
   modport slave (
      input  s_valid, s_data, flush, fc_busy,
      output s_ready, valid_out, lanes, beat_idx, last_beat, fill_count, vec_count
   );
endinterface

// File: rtl/fc_input_packer.sv
// Collects a vector of VEC words from a word stream, then replays it to the
// FC layer as BEATS wide beats of LANES words once the layer is free.
module fc_input_packer #(
   parameter int unsigned DATA_BITS = 32,
   parameter int unsigned LANES     = 128,
   parameter int unsigned BEATS     = 4
) (
   input logic              clk,
   input logic              rst,
   fc_input_packer_if.slave bus
);
   localparam int unsigned VEC    = LANES * BEATS;
   localparam int unsigned IDX_W  = (VEC > 1) ? $clog2(VEC) : 1;
   localparam int unsigned FILL_W = $clog2(VEC + 1);
   localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned VCNT_W = 16;
   localparam int unsigned BUS_W  = LANES * DATA_BITS;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_WAIT = 2'd1,
      ST_SEND = 2'd2
   } state_t;

   state_t               state_q;
   logic [FILL_W-1:0]    fill_count_q;
   logic [VCNT_W-1:0]    vec_count_q;
   logic                 valid_out_q;
   logic                 last_beat_q;
   logic [BEAT_W-1:0]    beat_idx_q;
   logic [BUS_W-1:0]     lanes_q;
   logic [BUS_W-1:0]     lanes_d;
   logic [BEAT_W-1:0]    rd_beat;
   logic                 accept;
   logic [DATA_BITS-1:0] buf_q [VEC];

   // Ready comes straight from the registered state; held low while in reset.
   assign bus.s_ready    = (state_q == ST_FILL) && !rst;
   // Flush wins over a word presented in the same cycle.
   assign accept         = bus.s_valid && bus.s_ready && !bus.flush;

   assign bus.valid_out  = valid_out_q;
   assign bus.lanes      = lanes_q;
   assign bus.beat_idx   = beat_idx_q;
   assign bus.last_beat  = last_beat_q;
   assign bus.fill_count = fill_count_q;
   assign bus.vec_count  = vec_count_q;

   // Vector buffer: word n lands at index n, i.e. beat n/LANES, lane n%LANES.
   always_ff @(posedge clk) begin
      if (accept) begin
         buf_q[fill_count_q[IDX_W-1:0]] <= bus.s_data;
      end
   end

   // Gather the beat that will be presented after the next edge.
   always_comb begin
      rd_beat = '0;
      lanes_d = '0;
      if (state_q == ST_SEND) begin
         rd_beat = beat_idx_q + BEAT_W'(1);
      end
      for (int k = 0; k < int'(LANES); k++) begin
         lanes_d[k*DATA_BITS +: DATA_BITS] = buf_q[IDX_W'(int'(rd_beat) * int'(LANES) + k)];
      end
   end

   // FILL / WAIT / SEND sequencing with registered beat outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_FILL;
         fill_count_q <= '0;
         vec_count_q  <= '0;
         valid_out_q  <= 1'b0;
         lanes_q      <= '0;
         beat_idx_q   <= '0;
         last_beat_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_FILL: begin
               if (bus.flush) begin
                  fill_count_q <= '0;
               end else if (accept) begin
                  fill_count_q <= fill_count_q + FILL_W'(1);
                  if (fill_count_q == FILL_W'(VEC - 1)) begin
                     state_q <= ST_WAIT;
                  end
               end
            end

            ST_WAIT: begin
               if (bus.flush) begin
                  fill_count_q <= '0;
                  state_q      <= ST_FILL;
               end else if (!bus.fc_busy) begin
                  state_q     <= ST_SEND;
                  valid_out_q <= 1'b1;
                  beat_idx_q  <= '0;
                  lanes_q     <= lanes_d;
                  last_beat_q <= (BEATS == 1);
               end
            end

            ST_SEND: begin
               // Burst runs to completion; flush and fc_busy are not looked at here.
               if (beat_idx_q == BEAT_W'(BEATS - 1)) begin
                  state_q      <= ST_FILL;
                  fill_count_q <= '0;
                  vec_count_q  <= vec_count_q + VCNT_W'(1);
                  valid_out_q  <= 1'b0;
                  lanes_q      <= '0;
                  beat_idx_q   <= '0;
                  last_beat_q  <= 1'b0;
               end else begin
                  beat_idx_q  <= rd_beat;
                  lanes_q     <= lanes_d;
                  last_beat_q <= (rd_beat == BEAT_W'(BEATS - 1));
               end
            end

            default: begin
               state_q <= ST_FILL;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fc_input_packer.sv
// Bench for fc_input_packer: word scoreboard checked on every output beat,
// a per-cycle table for the busy/flush burst case, and hand sequences.
module tb_fc_input_packer;
   localparam int DB  = 32;
   localparam int LN  = 128;
   localparam int BT  = 4;
   localparam int VEC = LN * BT;

   typedef struct {
      int busy;
      int flush;
      int exp_valid;
      int exp_ready;
      int exp_beat;
      int exp_last;
      int exp_fill;
   } row_t;

   logic clk = 1'b0;
   logic rst;

   fc_input_packer_if #(.DATA_BITS(DB), .LANES(LN), .BEATS(BT)) bus ();

   fc_input_packer #(.DATA_BITS(DB), .LANES(LN), .BEATS(BT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int          n_vec    = 0;
   int          n_err    = 0;
   int          mon_beat = 0;
   int          exp_vec  = 0;
   logic [DB-1:0] next_val = '0;
   logic [DB-1:0] exp_q[$];
   row_t        tbl[16];

   task automatic chk(input string name, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Advance one cycle and check the beat bus against the scoreboard.
   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.valid_out) begin
         if (exp_q.size() < LN) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_underflow: got a beat with only %0d words expected", exp_q.size());
         end else begin
            int bad = -1;
            logic [DB-1:0] gw = '0;
            logic [DB-1:0] ew = '0;
            for (int k = 0; k < LN; k++) begin
               logic [DB-1:0] w;
               w = exp_q.pop_front();
               if (bus.lanes[k*DB +: DB] !== w && bad < 0) begin
                  bad = k;
                  gw  = bus.lanes[k*DB +: DB];
                  ew  = w;
               end
            end
            n_vec++;
            if (bad >= 0) begin
               n_err++;
               $display("FAIL beat_data: lane %0d got %08h expected %08h (beat %0d)", bad, gw, ew, mon_beat);
            end
         end
         chk("beat_idx", int'(bus.beat_idx), mon_beat);
         chk("last_beat", int'(bus.last_beat), int'(mon_beat == BT - 1));
         mon_beat = (mon_beat + 1) % BT;
      end else begin
         chk("idle_lanes_zero", int'(|bus.lanes), 0);
         chk("idle_beat_idx", int'(bus.beat_idx), 0);
         chk("idle_last_beat", int'(bus.last_beat), 0);
      end
   endtask

   // Push n words (gap_pct % chance of an idle cycle each cycle).
   task automatic fill_words(input int n, input int gap_pct);
      int got = 0;
      for (int cyc = 0; cyc < 20000 && got < n; cyc++) begin
         if (int'($urandom_range(99)) < gap_pct) begin
            bus.s_valid = 1'b0;
            bus.s_data  = 32'hFFFF_0000 | DB'(cyc);
         end else begin
            chk("fill_ready", int'(bus.s_ready), 1);
            chk("fill_count", int'(bus.fill_count), int'(exp_q.size()) % VEC);
            bus.s_valid = 1'b1;
            bus.s_data  = next_val;
            exp_q.push_back(next_val);
            next_val = next_val + 1;
            got++;
         end
         tick();
      end
      bus.s_valid = 1'b0;
      if (got < n) chk("fill_timeout", got, n);
   endtask

   task automatic fill_vec(input int gap_pct);
      fill_words(VEC, gap_pct);
      chk("full_fill_count", int'(bus.fill_count), VEC);
      chk("full_ready", int'(bus.s_ready), 0);
   endtask

   // From the first WAIT cycle with fc_busy low: one wait cycle, four beats, back to FILL.
   task automatic run_burst();
      chk("wait_valid", int'(bus.valid_out), 0);
      for (int b = 0; b < BT; b++) begin
         bus.s_valid = 1'($urandom_range(1));
         bus.s_data  = 32'hDEAD_0000 | DB'(b);
         tick();
         chk("burst_valid", int'(bus.valid_out), 1);
         chk("burst_ready", int'(bus.s_ready), 0);
         chk("burst_fill", int'(bus.fill_count), VEC);
      end
      bus.s_valid = 1'b0;
      tick();
      exp_vec++;
      chk("post_valid", int'(bus.valid_out), 0);
      chk("post_ready", int'(bus.s_ready), 1);
      chk("post_fill", int'(bus.fill_count), 0);
      chk("post_vec_count", int'(bus.vec_count), exp_vec % 65536);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 10; i++) tbl[i] = '{1, 0, 0, 0, 0, 0, VEC};
      tbl[10] = '{0, 0, 1, 0, 0, 0, VEC};
      tbl[11] = '{1, 0, 1, 0, 1, 0, VEC};
      tbl[12] = '{1, 1, 1, 0, 2, 0, VEC};
      tbl[13] = '{0, 1, 1, 0, 3, 1, VEC};
      tbl[14] = '{1, 0, 0, 1, 0, 0, 0};
      tbl[15] = '{0, 0, 0, 1, 0, 0, 0};

      rst         = 1'b1;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.flush   = 1'b0;
      bus.fc_busy = 1'b0;

      // Reset state.
      tick();
      tick();
      chk("rst_valid", int'(bus.valid_out), 0);
      chk("rst_ready", int'(bus.s_ready), 0);
      chk("rst_fill", int'(bus.fill_count), 0);
      chk("rst_vec", int'(bus.vec_count), 0);
      rst = 1'b0;
      tick();
      chk("rel_ready", int'(bus.s_ready), 1);

      // Words 0..511 with value = index, fc_busy low.
      next_val = '0;
      fill_vec(0);
      run_burst();

      // Busy for 10 cycles, then flush/busy toggling during the burst.
      bus.fc_busy = 1'b1;
      next_val = 32'h0001_0000;
      fill_vec(0);
      for (int i = 0; i < 16; i++) begin
         bus.fc_busy = 1'(tbl[i].busy);
         bus.flush   = 1'(tbl[i].flush);
         tick();
         chk("tbl_valid", int'(bus.valid_out), tbl[i].exp_valid);
         chk("tbl_ready", int'(bus.s_ready), tbl[i].exp_ready);
         chk("tbl_beat", int'(bus.beat_idx), tbl[i].exp_beat);
         chk("tbl_last", int'(bus.last_beat), tbl[i].exp_last);
         chk("tbl_fill", int'(bus.fill_count), tbl[i].exp_fill);
      end
      bus.flush = 1'b0;
      exp_vec++;
      chk("tbl_vec_count", int'(bus.vec_count), exp_vec);

      // Flush while waiting on a busy FC layer drops the full vector.
      bus.fc_busy = 1'b1;
      fill_vec(0);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      exp_q.delete();
      chk("wflush_fill", int'(bus.fill_count), 0);
      chk("wflush_ready", int'(bus.s_ready), 1);
      chk("wflush_vec", int'(bus.vec_count), exp_vec);

      // Flush with a word present after 300 words: the word is dropped.
      bus.fc_busy = 1'b0;
      fill_words(300, 0);
      chk("pflush_pre_fill", int'(bus.fill_count), 300);
      bus.s_valid = 1'b1;
      bus.s_data  = 32'hBAD0_BAD0;
      bus.flush   = 1'b1;
      tick();
      bus.s_valid = 1'b0;
      bus.flush   = 1'b0;
      exp_q.delete();
      chk("pflush_fill", int'(bus.fill_count), 0);
      chk("pflush_ready", int'(bus.s_ready), 1);
      next_val = 32'h0002_0000;
      fill_vec(0);
      run_burst();

      // Reset during beat 2 aborts the burst.
      next_val = 32'h0003_0000;
      fill_vec(0);
      for (int b = 0; b < 3; b++) begin
         tick();
         chk("abort_valid", int'(bus.valid_out), 1);
      end
      rst = 1'b1;
      tick();
      chk("abort_rst_valid", int'(bus.valid_out), 0);
      chk("abort_rst_vec", int'(bus.vec_count), 0);
      chk("abort_rst_fill", int'(bus.fill_count), 0);
      chk("abort_rst_ready", int'(bus.s_ready), 0);
      exp_q.delete();
      mon_beat = 0;
      exp_vec  = 0;
      rst = 1'b0;
      tick();
      chk("abort_rel_ready", int'(bus.s_ready), 1);

      // Three vectors with random input gaps.
      next_val = 32'h0004_0000;
      for (int v = 0; v < 3; v++) begin
         fill_vec(50);
         run_burst();
      end
      chk("rand_vec_count", int'(bus.vec_count), 3);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fc_input_packer.md
FC_INPUT_PACKER -- requirements
Module: fc_input_packer

Interface
REQ-001 SHALL have parameter DATA_BITS, default 32, word width of one float32 element.
REQ-002 SHALL have parameter LANES, default 128, words per output beat; lanes map to FC ports data_in_1..data_in_LANES.
REQ-003 SHALL have parameter BEATS, default 4, beats per vector; vector length VEC = LANES*BEATS = 512.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port s_valid, input, 1, upstream word valid.
REQ-008 SHALL have port s_data, input, DATA_BITS, upstream word.
REQ-009 SHALL have port s_ready, output, 1, packer accepts a word this cycle.
REQ-010 SHALL have port flush, input, 1, discard the partially or fully buffered vector.
REQ-011 SHALL have port fc_busy, input, 1, downstream FC layer cannot start a new burst.
REQ-012 SHALL have port valid_out, output, 1, drives FC valid_in.
REQ-013 SHALL have port lanes, output, LANES*DATA_BITS, beat data; lane k = bits [32k+31:32k] feeds data_in_(k+1).
REQ-014 SHALL have port beat_idx, output, 2, index of the current beat, 0..BEATS-1.
REQ-015 SHALL have port last_beat, output, 1, high with the final beat of a vector.
REQ-016 SHALL have port fill_count, output, 10, words buffered in the current vector, 0..512.
REQ-017 SHALL have port vec_count, output, 16, vectors fully sent, wraps 65535->0.

Function
REQ-018 SHALL implement states FILL, WAIT, SEND; s_ready = (state==FILL), decoded from registered state only.
REQ-019 FILL: each cycle with s_valid&&s_ready SHALL store s_data at word index fill_count and increment fill_count.
REQ-020 Word n (0..511) SHALL go to beat n/LANES, lane n%LANES.
REQ-021 On the edge accepting word 511, the block SHALL enter WAIT with fill_count=512 and s_ready=0 the next cycle.
REQ-022 WAIT: on an edge with fc_busy=0, the block SHALL enter SEND; valid_out=1 with beat 0 appears the following cycle (1-cycle latency).
REQ-023 SEND SHALL assert valid_out for exactly BEATS consecutive cycles, with beats 0,1,2,3 in order; fc_busy SHALL be ignored during SEND and the burst never interrupted.
REQ-024 last_beat SHALL be high only in the beat_idx=3 cycle; after it the block SHALL enter FILL with fill_count=0, s_ready=1, and vec_count incremented.
REQ-025 lanes and beat_idx SHALL be 0 whenever valid_out=0.
REQ-026 flush in FILL or WAIT SHALL set fill_count=0 and state FILL next cycle; a word presented in the same cycle is dropped (flush wins).
REQ-027 flush in SEND SHALL be ignored.
REQ-028 fc_busy=1 held indefinitely SHALL hold WAIT with data intact and s_ready=0.
REQ-029 Storage SHALL be a single VEC x DATA_BITS buffer; no input accepted from WAIT entry until SEND completes.

Reset
REQ-030 rst=1 at an edge SHALL force state FILL, fill_count=0, vec_count=0, valid_out=0, lanes=0, beat_idx=0, last_beat=0; s_ready=0 while rst is high.
REQ-031 rst mid-FILL or mid-SEND SHALL abort immediately; the next cycle shows valid_out=0 and buffered data is treated as discarded.

Verification
REQ-032 Reset release, stream words 0..511 with value = index, fc_busy=0 -> s_ready drops after word 511; next-next cycle valid_out=1 for 4 cycles; beat b lane k = 128b+k; last_beat only on beat 3; vec_count=1.
REQ-033 Fill complete, fc_busy=1 for 10 cycles -> valid_out stays 0, s_ready=0; fc_busy falls -> burst starts one cycle after the sampling edge, data unchanged.
REQ-034 Load 300 words, assert flush with s_valid=1 -> fill_count=0 next cycle; word 300 is not stored; the next 512 words form a clean vector.
REQ-035 Assert flush and fc_busy toggling during SEND beat 1 -> all 4 beats are still emitted; vec_count increments.
REQ-036 rst=1 during SEND beat 2 -> valid_out=0 next cycle, vec_count=0, fill_count=0, state FILL.
REQ-037 Random s_valid gaps (50%) over 3 vectors -> lane data matches the input order exactly; vec_count=3; no beat is missing or duplicated.
